// File: rtl/demux_l1.sv
// Level-1 receive demux: each of two byte lanes is split into even/odd pairs on two output lanes.
// Optional idle-timeout flush of stranded half pairs is built when DEMUX_L1_FLUSH_EN is defined.
module demux_l1 #(
  parameter int FLUSH_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] dataIn0,
  input  logic       validIn0,
  input  logic [7:0] dataIn1,
  input  logic       validIn1,
  output logic [7:0] dataOut0,
  output logic [7:0] dataOut1,
  output logic [7:0] dataOut2,
  output logic [7:0] dataOut3,
  output logic       validOut0,
  output logic       validOut1,
  output logic       validOut2,
  output logic       validOut3
`ifdef DEMUX_L1_FLUSH_EN
  ,
  output logic       dropOut0,
  output logic       dropOut1
`endif
);

  typedef enum logic {
    EVEN = 1'b0,
    ODD  = 1'b1
  } phase_t;

  localparam int NUM_LANES = 2;

  logic [7:0] din_w   [NUM_LANES];
  logic       vin_w   [NUM_LANES];
  logic [7:0] even_w  [NUM_LANES];
  logic [7:0] odd_w   [NUM_LANES];
  logic       valid_w [NUM_LANES];
`ifdef DEMUX_L1_FLUSH_EN
  logic       drop_w  [NUM_LANES];
`endif

  assign din_w[0] = dataIn0;
  assign din_w[1] = dataIn1;
  assign vin_w[0] = validIn0;
  assign vin_w[1] = validIn1;

  // An illegal FLUSH_CYCLES leaves this marker block in the elaborated hierarchy.
  if (FLUSH_CYCLES < 1) begin : g_flush_cycles_out_of_range
  end

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    phase_t     state_q, state_d;
    logic [7:0] hold_q, hold_d;
    logic [7:0] even_q, even_d;
    logic [7:0] odd_q, odd_d;
    logic       valid_q, valid_d;
`ifdef DEMUX_L1_FLUSH_EN
    localparam int CW = $clog2(FLUSH_CYCLES + 1);
    localparam logic [CW-1:0] IDLE_LAST = CW'(FLUSH_CYCLES - 1);
    logic [CW-1:0] idle_q, idle_d;
    logic          drop_q, drop_d;
`endif

    always_ff @(posedge clk) begin
      if (reset) begin
        state_q <= EVEN;
        hold_q  <= 8'h00;
        even_q  <= 8'h00;
        odd_q   <= 8'h00;
        valid_q <= 1'b0;
`ifdef DEMUX_L1_FLUSH_EN
        idle_q  <= '0;
        drop_q  <= 1'b0;
`endif
      end else begin
        state_q <= state_d;
        hold_q  <= hold_d;
        even_q  <= even_d;
        odd_q   <= odd_d;
        valid_q <= valid_d;
`ifdef DEMUX_L1_FLUSH_EN
        idle_q  <= idle_d;
        drop_q  <= drop_d;
`endif
      end
    end

    always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      even_d  = even_q;
      odd_d   = odd_q;
      valid_d = 1'b0;
`ifdef DEMUX_L1_FLUSH_EN
      idle_d  = idle_q;
      drop_d  = 1'b0;
`endif
      case (state_q)
        EVEN: begin
          if (vin_w[gi]) begin
            hold_d  = din_w[gi];
            state_d = ODD;
          end
`ifdef DEMUX_L1_FLUSH_EN
          idle_d = '0;
`endif
        end
        ODD: begin
          if (vin_w[gi]) begin
            even_d  = hold_q;
            odd_d   = din_w[gi];
            valid_d = 1'b1;
            state_d = EVEN;
`ifdef DEMUX_L1_FLUSH_EN
            idle_d  = '0;
`endif
          end
`ifdef DEMUX_L1_FLUSH_EN
          // The FLUSH_CYCLES-th idle cycle in a row abandons the held even byte.
          else if (idle_q == IDLE_LAST) begin
            state_d = EVEN;
            hold_d  = 8'h00;
            drop_d  = 1'b1;
            idle_d  = '0;
          end else begin
            idle_d = idle_q + 1'b1;
          end
`endif
        end
        default: state_d = EVEN;
      endcase
    end

    assign even_w[gi]  = even_q;
    assign odd_w[gi]   = odd_q;
    assign valid_w[gi] = valid_q;
`ifdef DEMUX_L1_FLUSH_EN
    assign drop_w[gi]  = drop_q;
`endif
  end

  assign dataOut0  = even_w[0];
  assign dataOut1  = odd_w[0];
  assign dataOut2  = even_w[1];
  assign dataOut3  = odd_w[1];
  assign validOut0 = valid_w[0];
  assign validOut1 = valid_w[0];
  assign validOut2 = valid_w[1];
  assign validOut3 = valid_w[1];
`ifdef DEMUX_L1_FLUSH_EN
  assign dropOut0  = drop_w[0];
  assign dropOut1  = drop_w[1];
`endif

endmodule
